// File: rtl/sumador_restador_serie_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding and op codes.
package sumador_restador_serie_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_SUMA  = 1'b0;
    localparam logic OP_RESTA = 1'b1;

endpackage

// File: rtl/sumador_restador_serie_if.sv
// Start/busy/done handshake, operands and result/flags of the serial adder/subtractor.
interface sumador_restador_serie_if #(parameter int WIDTH = 8);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (output start, op, a, b,
                    input  busy, done, s, cout, ovf, zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, s, cout, ovf, zero);
endinterface

// File: rtl/sumador_restador_serie_digito.sv
// Combinational DIGIT-bit ripple slice of full-adder cells; also exposes the carry into the top bit.
module sumador_restador_serie_digito #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/sumador_restador_serie.sv
// Multi-cycle two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with start/busy/done handshake and carry/overflow/zero flags.
module sumador_restador_serie
    import sumador_restador_serie_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    sumador_restador_serie_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     acc_q;
    logic                 carry_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [DIGIT-1:0]       sl_s;
    logic                   sl_cout;
    logic                   sl_cmsb;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH+DIGIT-1:0] acc_sh;
    logic [WIDTH-1:0]       acc_next;
    logic                   last;

    sumador_restador_serie_digito #(.DIGIT(DIGIT)) u_digito (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // New digit enters at the MSB end so the result is right-aligned after N shifts.
    assign acc_cat  = {sl_s, acc_q};
    assign acc_sh   = acc_cat >> DIGIT;
    assign acc_next = acc_sh[WIDTH-1:0];
    assign last     = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.s     <= '0;
            bus.cout  <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.zero  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                    if (bus.start) begin
                        // Subtraction as a + ~b + 1: invert B and seed the carry.
                        a_q      <= bus.a;
                        b_q      <= (bus.op == OP_RESTA) ? ~bus.b : bus.b;
                        carry_q  <= (bus.op == OP_RESTA);
                        cnt_q    <= '0;
                        state    <= S_RUN;
                        bus.busy <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_next;
                    carry_q <= sl_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.s    <= acc_next;
                        bus.cout <= sl_cout;
                        bus.ovf  <= sl_cmsb ^ sl_cout;
                        bus.zero <= (acc_next == '0);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_restador_serie.sv
// Directed-vector bench: 8-bit instance with 1-bit digits and 8-bit instance with 4-bit digits.
module tb_sumador_restador_serie;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sumador_restador_serie_if #(.WIDTH(8)) i8 ();
    sumador_restador_serie_if #(.WIDTH(8)) i4 ();

    sumador_restador_serie #(.WIDTH(8), .DIGIT(1)) dut8 (.clk(clk), .rst(rst), .bus(i8));
    sumador_restador_serie #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation on the selected instance, count busy cycles until done or timeout.
    task automatic run_op(input bit sel4, input logic o, input logic [7:0] x, input logic [7:0] y,
                          output int nbusy, output bit got);
        @(negedge clk);
        if (sel4) begin i4.start = 1'b1; i4.op = o; i4.a = x; i4.b = y; end
        else      begin i8.start = 1'b1; i8.op = o; i8.a = x; i8.b = y; end
        nbusy = 0;
        got   = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            i4.start = 1'b0;
            i8.start = 1'b0;
            if (sel4) begin
                if (i4.done) got = 1'b1; else if (i4.busy) nbusy++;
            end else begin
                i8.a = ~x; i8.b = y ^ 8'h5A;
                if (i8.done) got = 1'b1; else if (i8.busy) nbusy++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i8.start = 1'b0; i8.op = 1'b0; i8.a = '0; i8.b = '0;
        i4.start = 1'b0; i4.op = 1'b0; i4.a = '0; i4.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i8.busy, i8.done, i8.cout, i8.ovf, i8.zero} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 00000", {i8.busy, i8.done, i8.cout, i8.ovf, i8.zero});
        end
        checks++;
        if (i8.s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h expected 00", i8.s); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vec(input string name, input bit sel4, input logic o, input logic [7:0] x,
                            input logic [7:0] y, input int exp_busy, input logic [7:0] exp_s,
                            input logic [2:0] exp_f);
        int          nb;
        bit          got;
        logic [7:0]  s_obs;
        logic [2:0]  f_obs;
        run_op(sel4, o, x, y, nb, got);
        s_obs = sel4 ? i4.s : i8.s;
        f_obs = sel4 ? {i4.cout, i4.ovf, i4.zero} : {i8.cout, i8.ovf, i8.zero};
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL %s done_seen: got %b expected 1", name, got); end
        checks++;
        if (nb !== exp_busy) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, nb, exp_busy); end
        checks++;
        if (s_obs !== exp_s) begin errors++; $display("FAIL %s s: got %h expected %h", name, s_obs, exp_s); end
        checks++;
        if (f_obs !== exp_f) begin errors++; $display("FAIL %s cout_ovf_zero: got %b expected %b", name, f_obs, exp_f); end
    endtask

    task automatic test_hold;
        @(negedge clk);
        checks++;
        if (i8.done !== 1'b0) begin errors++; $display("FAIL hold_done_pulse: got %b expected 0", i8.done); end
        repeat (3) @(negedge clk);
        checks++;
        if (i8.s !== 8'h7F || i8.busy !== 1'b0) begin
            errors++; $display("FAIL hold_s: got s=%h busy=%b expected s=7f busy=0", i8.s, i8.busy);
        end
    endtask

    task automatic test_start_ignored;
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        @(negedge clk);
        i8.start = 1'b1; i8.op = 1'b0; i8.a = 8'h10; i8.b = 8'h20;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k < 4) begin i8.a = 8'h55 + 8'(k); i8.b = 8'hAA; i8.op = 1'b1; end
            else i8.start = 1'b0;
            if (i8.done) got = 1'b1; else if (i8.busy) nb++;
        end
        checks++;
        if (got !== 1'b1 || nb !== 8) begin
            errors++; $display("FAIL ignore_timing: got done=%b busy=%0d expected done=1 busy=8", got, nb);
        end
        checks++;
        if (i8.s !== 8'h30) begin errors++; $display("FAIL ignore_s: got %h expected 30", i8.s); end
    endtask

    task automatic test_back_to_back;
        int nb;
        int gap;
        bit got;
        bit got2;
        run_op(1'b0, 1'b0, 8'h12, 8'h34, nb, got);
        checks++;
        if (got !== 1'b1 || i8.s !== 8'h46) begin
            errors++; $display("FAIL b2b_first: got done=%b s=%h expected done=1 s=46", got, i8.s);
        end
        checks++;
        if (i8.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done: got %b expected 0", i8.busy); end
        i8.start = 1'b1; i8.op = 1'b1; i8.a = 8'h50; i8.b = 8'h20;
        gap  = 0;
        got2 = 1'b0;
        for (int k = 0; k < 40 && !got2; k++) begin
            @(negedge clk);
            i8.start = 1'b0;
            gap++;
            if (i8.done) got2 = 1'b1;
        end
        checks++;
        if (got2 !== 1'b1 || gap !== 9) begin
            errors++; $display("FAIL b2b_gap: got done=%b gap=%0d expected done=1 gap=9", got2, gap);
        end
        checks++;
        if (i8.s !== 8'h30 || {i8.cout, i8.ovf, i8.zero} !== 3'b100) begin
            errors++; $display("FAIL b2b_second: got s=%h f=%b expected s=30 f=100", i8.s, {i8.cout, i8.ovf, i8.zero});
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        @(negedge clk);
        i8.start = 1'b1; i8.op = 1'b0; i8.a = 8'h11; i8.b = 8'h22;
        @(posedge clk);
        #1 i8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({i8.busy, i8.done, i8.cout, i8.ovf, i8.zero} !== 5'b0 || i8.s !== 8'h00) begin
            errors++; $display("FAIL midrst_clear: got ctl=%b s=%h expected ctl=00000 s=00",
                               {i8.busy, i8.done, i8.cout, i8.ovf, i8.zero}, i8.s);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (i8.done || i8.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got activity=%b expected 0", seen); end
        test_vec("after_rst", 1'b0, 1'b0, 8'h11, 8'h22, 8, 8'h33, 3'b000);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_vec("add_3c_05",  1'b0, 1'b0, 8'h3C, 8'h05, 8, 8'h41, 3'b000);
        test_vec("sub_05_05",  1'b0, 1'b1, 8'h05, 8'h05, 8, 8'h00, 3'b101);
        test_vec("add_7f_01",  1'b0, 1'b0, 8'h7F, 8'h01, 8, 8'h80, 3'b010);
        test_vec("sub_00_01",  1'b0, 1'b1, 8'h00, 8'h01, 8, 8'hFF, 3'b000);
        test_vec("sub_80_01",  1'b0, 1'b1, 8'h80, 8'h01, 8, 8'h7F, 3'b110);
        test_hold();
        test_vec("d4_ff_01",   1'b1, 1'b0, 8'hFF, 8'h01, 2, 8'h00, 3'b101);
        test_vec("d4_sub_10_20", 1'b1, 1'b1, 8'h10, 8'h20, 2, 8'hF0, 3'b000);
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
